// File: rtl/cvm_pkg.sv
// Shared types and default coin values for the parametrised coin vending controller.
package cvm_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        PAY     = 2'd2,
        GAP     = 2'd3
    } cvm_state_t;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        SH = 2'd1,
        SP = 2'd2
    } det_state_t;

    localparam int DEF_PRICE    = 5;
    localparam int DEF_VAL_N    = 1;
    localparam int DEF_VAL_D    = 2;
    localparam int DEF_VAL_Q    = 5;
    localparam int DEF_CREDIT_W = 4;

endpackage

// File: rtl/coin_pulse.sv
// Coin sensor pulse detector: one-cycle pulse in the cycle after a raw high falls.
module coin_pulse
    import cvm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    det_state_t r_state;
    det_state_t w_next;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S0:      w_next = raw ? SH : S0;
            SH:      w_next = raw ? SH : SP;
            SP:      w_next = raw ? SH : S0;
            default: w_next = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    assign pulse = (r_state == SP);

endmodule

// File: rtl/cvm_param.sv
// Coin vending controller: credits coins, dispenses at PRICE, pays change/refund
// as a nickel/dime pulse train with one idle cycle between pulses.
module cvm_param
    import cvm_pkg::*;
#(
    parameter int PRICE    = DEF_PRICE,
    parameter int VAL_N    = DEF_VAL_N,
    parameter int VAL_D    = DEF_VAL_D,
    parameter int VAL_Q    = DEF_VAL_Q,
    parameter int CREDIT_W = DEF_CREDIT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                n_raw,
    input  logic                d_raw,
    input  logic                q_raw,
    input  logic                cancel,
    output logic                del,
    output logic                rn,
    output logic                rd,
    output logic                busy,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit
);

    if (VAL_N != 1) begin : g_chk_valn
        $error("cvm_param: VAL_N must be 1");
    end
    if (PRICE < 1) begin : g_chk_price
        $error("cvm_param: PRICE must be at least 1");
    end
    if ((1 << CREDIT_W) <= (PRICE - 1 + VAL_N + VAL_D + VAL_Q)) begin : g_chk_width
        $error("cvm_param: CREDIT_W too narrow for worst-case sum");
    end

    cvm_state_t          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_remain;
    logic                r_coin_rej;

    logic                w_pn, w_pd, w_pq, w_any;
    logic [CREDIT_W-1:0] w_sum;
    logic                w_pay_dime;
    logic [CREDIT_W-1:0] w_pay_next;

    coin_pulse u_det_n (.clk(clk), .rst(rst), .raw(n_raw), .pulse(w_pn));
    coin_pulse u_det_d (.clk(clk), .rst(rst), .raw(d_raw), .pulse(w_pd));
    coin_pulse u_det_q (.clk(clk), .rst(rst), .raw(q_raw), .pulse(w_pq));

    assign w_any = w_pn | w_pd | w_pq;

    // Coins arriving together are all credited in one step.
    assign w_sum = r_credit
                 + (w_pn ? CREDIT_W'(VAL_N) : '0)
                 + (w_pd ? CREDIT_W'(VAL_D) : '0)
                 + (w_pq ? CREDIT_W'(VAL_Q) : '0);

    assign w_pay_dime = (r_remain >= CREDIT_W'(VAL_D));
    assign w_pay_next = r_remain - (w_pay_dime ? CREDIT_W'(VAL_D) : CREDIT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= COLLECT;
            r_credit   <= '0;
            r_remain   <= '0;
            r_coin_rej <= 1'b0;
        end else begin
            r_coin_rej <= (r_state != COLLECT) && w_any;
            unique case (r_state)
                COLLECT: begin
                    if (w_sum >= CREDIT_W'(PRICE)) begin
                        r_state  <= VEND;
                        r_remain <= w_sum - CREDIT_W'(PRICE);
                        r_credit <= '0;
                    end else if (cancel && (w_sum != '0)) begin
                        r_state  <= PAY;
                        r_remain <= w_sum;
                        r_credit <= '0;
                    end else begin
                        r_credit <= w_sum;
                    end
                end
                VEND: begin
                    r_state <= (r_remain != '0) ? PAY : COLLECT;
                end
                PAY: begin
                    r_remain <= w_pay_next;
                    r_state  <= (w_pay_next != '0) ? GAP : COLLECT;
                end
                GAP: begin
                    r_state <= PAY;
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    // Pulse outputs are decoded from registered state only.
    assign del      = (r_state == VEND);
    assign rd       = (r_state == PAY) &&  w_pay_dime;
    assign rn       = (r_state == PAY) && !w_pay_dime;
    assign busy     = (r_state != COLLECT);
    assign coin_rej = r_coin_rej;
    assign credit   = r_credit;

endmodule

// File: tb/tb_cvm_param.sv
// Self-checking bench for cvm_param: expected output pulses are queued with their
// cycle stamps as stimulus is driven and matched by a monitor on the falling edge.
module tb_cvm_param;

    localparam logic [3:0] K_DEL = 4'b1000;
    localparam logic [3:0] K_RN  = 4'b0100;
    localparam logic [3:0] K_RD  = 4'b0010;
    localparam logic [3:0] K_REJ = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       n_raw, d_raw, q_raw, cancel;
    logic       del, rn, rd, busy, coin_rej;
    logic [3:0] credit;

    int  cyc;
    int  n_checks;
    int  n_errors;
    ev_t sb[$];

    cvm_param u_dut (
        .clk     (clk),
        .rst     (rst),
        .n_raw   (n_raw),
        .d_raw   (d_raw),
        .q_raw   (q_raw),
        .cancel  (cancel),
        .del     (del),
        .rn      (rn),
        .rd      (rd),
        .busy    (busy),
        .coin_rej(coin_rej),
        .credit  (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Keep the scoreboard ordered by cycle; events due in the same cycle merge.
    function automatic void expect_ev(input int c, input logic [3:0] k);
        ev_t e;
        int unsigned i;
        for (i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc == c) begin
                e = sb[i];
                e.kind = e.kind | k;
                sb[i] = e;
                return;
            end
            if (sb[i].cyc > c) break;
        end
        e.cyc  = c;
        e.kind = k;
        sb.insert(i, e);
    endfunction

    logic [3:0] mon_v;
    ev_t        mon_e;
    always @(negedge clk) begin
        mon_v = {del, rn, rd, coin_rej};
        if (mon_v != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", int'(mon_v), 0);
            end else begin
                mon_e = sb.pop_front();
                check("ev_cycle", cyc, mon_e.cyc);
                check("ev_kind", int'(mon_v), int'(mon_e.kind));
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            check("missed_pulse", 0, int'(mon_e.kind));
        end
    end

    // Called at a falling edge; returns k, the cycle the detector pulse occupies.
    task automatic coin(input logic n, input logic d, input logic q, output int k);
        n_raw = n; d_raw = d; q_raw = q;
        @(negedge clk);
        n_raw = 1'b0; d_raw = 1'b0; q_raw = 1'b0;
        k = cyc + 1;
    endtask

    task automatic nickels(input int cnt);
        int k;
        for (int i = 1; i <= cnt; i++) begin
            coin(1'b1, 1'b0, 1'b0, k);
            repeat (2) @(negedge clk);
            check("nickel_credit", int'(credit), i);
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_drain"}, sb.size(), 0);
        check({tag, "_idle"}, int'(busy), 0);
        sb.delete();
    endtask

    initial begin
        int k;
        int c;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        n_raw = 1'b0; d_raw = 1'b0; q_raw = 1'b0; cancel = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out", int'({del, rn, rd, coin_rej, busy}), 0);
        check("rst_credit", int'(credit), 0);

        // Five nickels: dispense exactly, no change.
        nickels(4);
        coin(1'b1, 1'b0, 1'b0, k);
        expect_ev(k + 1, K_DEL);
        repeat (2) @(negedge clk);
        check("n5_busy_vend", int'(busy), 1);
        check("n5_credit", int'(credit), 0);
        @(negedge clk);
        check("n5_busy_fall", int'(busy), 0);
        drain("n5");

        // Four nickels then a quarter: change of 4 as two dimes.
        nickels(4);
        coin(1'b0, 1'b0, 1'b1, k);
        expect_ev(k + 1, K_DEL);
        expect_ev(k + 2, K_RD);
        expect_ev(k + 4, K_RD);
        drain("n4q");
        check("n4q_credit", int'(credit), 0);

        // Dime then quarter: single dime of change.
        coin(1'b0, 1'b1, 1'b0, k);
        repeat (2) @(negedge clk);
        check("dq_credit", int'(credit), 2);
        coin(1'b0, 1'b0, 1'b1, k);
        expect_ev(k + 1, K_DEL);
        expect_ev(k + 2, K_RD);
        drain("dq");

        // Quarter alone.
        coin(1'b0, 1'b0, 1'b1, k);
        expect_ev(k + 1, K_DEL);
        drain("q");

        // Nickel, dime, cancel: refund dime then nickel.
        coin(1'b1, 1'b0, 1'b0, k);
        repeat (2) @(negedge clk);
        coin(1'b0, 1'b1, 1'b0, k);
        repeat (2) @(negedge clk);
        check("nd_credit", int'(credit), 3);
        c = cyc;
        cancel = 1'b1;
        expect_ev(c + 1, K_RD);
        expect_ev(c + 3, K_RN);
        @(negedge clk);
        cancel = 1'b0;
        drain("cancel");
        check("cancel_credit", int'(credit), 0);

        // Cancel with no credit does nothing.
        cancel = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("cancel0_busy", int'(busy), 0);
        end
        cancel = 1'b0;
        drain("cancel0");

        // Nickel and dime together, then cancel with a dime inserted during payout.
        coin(1'b1, 1'b1, 1'b0, k);
        repeat (2) @(negedge clk);
        check("nd_same_credit", int'(credit), 3);
        c = cyc;
        cancel = 1'b1;
        d_raw = 1'b1;
        expect_ev(c + 1, K_RD);
        expect_ev(c + 3, K_RN | K_REJ);
        @(negedge clk);
        cancel = 1'b0;
        d_raw = 1'b0;
        drain("rej");
        check("rej_credit", int'(credit), 0);

        // Nickel pulse coincident with cancel at credit 4: vend wins.
        nickels(4);
        coin(1'b1, 1'b0, 1'b0, k);
        expect_ev(k + 1, K_DEL);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        drain("vend_cancel");
        check("vend_cancel_credit", int'(credit), 0);

        // Reset in GAP after the first dime of a 4-nickel change.
        nickels(4);
        coin(1'b0, 1'b0, 1'b1, k);
        expect_ev(k + 1, K_DEL);
        expect_ev(k + 2, K_RD);
        while (cyc < k + 3) @(negedge clk);
        check("gap_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out", int'({del, rn, rd, coin_rej, busy}), 0);
        check("rst_mid_credit", int'(credit), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_mid_quiet", sb.size(), 0);
        check("rst_mid_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
